// File: rtl/tangle_uart_tx.sv
// tangle_uart_tx: memory-mapped 8N1 UART transmitter that sits beside the
// memory unit on the CPU data bus.
//
// Bus writes to BASE_ADDR queue a byte into a small circular FIFO. Writes to
// BASE_ADDR+1 with bit 3 set clear the sticky overflow flag. A serialiser
// drains the FIFO onto tx_o, LSB first. Each frame is one start bit, eight
// data bits and one stop bit, and each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk_i   in   1  system clock, rising edge
//   rst_i   in   1  asynchronous reset, active low
//   addr_i  in  16  CPU bus address (snooped)
//   data_i  in  16  CPU bus write data (snooped)
//   we_i    in   1  CPU bus write enable (snooped)
//   data_o  out 16  registered read data: STATUS word when the previous-cycle
//                   address was BASE_ADDR+1, otherwise zero
//   sel_o   out  1  registered: previous-cycle address hit either register
//   tx_o    out  1  serial output, idle high
//   irq_o   out  1  high while the FIFO is empty and the serialiser is idle
//
// STATUS word bit fields:
//   [0] busy, [1] full, [2] empty, [3] overflow, [7:4] FIFO count, [15:8] zero.
module tangle_uart_tx #(
  parameter logic [15:0] BASE_ADDR      = 16'hFF00,
  parameter int          CLKS_PER_BIT   = 104,
  parameter int          FIFO_DEPTH_LOG = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        we_i,
  output logic [15:0] data_o,
  output logic        sel_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int                DEPTH       = 1 << FIFO_DEPTH_LOG;
  localparam int                CNT_W       = FIFO_DEPTH_LOG + 1;
  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LOAD   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(DEPTH);
  localparam logic [15:0]       STATUS_ADDR = BASE_ADDR + 16'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                    state;
  logic [BAUD_W-1:0]         baud;
  logic [2:0]                bit_idx;
  logic [7:0]                shift;

  logic [7:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      overflow;

  logic empty;
  logic full;
  logic bit_done;
  logic pop;
  logic wr_data;
  logic push;
  logic drop;
  logic clr_ovf;
  logic [15:0] status;
  logic unused_data_bits;

  // Only the low byte is pushed and only bit 3 is decoded on a STATUS write.
  assign unused_data_bits = ^data_i[15:8];

  // Packs the STATUS word. The count is zero-extended, or truncated, into a
  // fixed 4-bit field.
  function automatic logic [15:0] pack_status(input logic busy_f,
                                              input logic full_f,
                                              input logic empty_f,
                                              input logic ovf_f,
                                              input logic [CNT_W-1:0] cnt_f);
    logic [3:0] cnt4;
    cnt4 = 4'(cnt_f);
    return {8'h00, cnt4, ovf_f, empty_f, full_f, busy_f};
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_CNT);
  assign bit_done = (baud == '0);

  // The serialiser pops when it is idle with data waiting, or when it is at
  // the end of a stop bit with data waiting. This condition must match the
  // transitions in the FSM below.
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_done));
  assign wr_data = we_i && (addr_i == BASE_ADDR);
  // A full FIFO still accepts a byte on the cycle it pops, because a slot frees up.
  assign push    = wr_data && (!full || pop);
  assign drop    = wr_data && full && !pop;
  assign clr_ovf = we_i && (addr_i == STATUS_ADDR) && data_i[3];

  assign status  = pack_status(state != IDLE, full, empty, overflow, count);
  assign irq_o   = empty && (state == IDLE);

  // FIFO storage: data only, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i[7:0];
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // Read path: this register stage presents the data one cycle after the address
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_o <= 16'h0000;
      sel_o  <= 1'b0;
    end else begin
      data_o <= (addr_i == STATUS_ADDR) ? status : 16'h0000;
      sel_o  <= (addr_i == BASE_ADDR) || (addr_i == STATUS_ADDR);
    end
  end

  // Serialiser FSM with registered tx_o
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      tx_o    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (!empty) begin
            shift <= mem[rd_ptr];
            baud  <= BAUD_LOAD;
            tx_o  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud    <= BAUD_LOAD;
            bit_idx <= 3'd0;
            tx_o    <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            baud <= BAUD_LOAD;
            if (bit_idx == 3'd7) begin
              tx_o  <= 1'b1;
              state <= STOP;
            end else begin
              // The next bit is shift[1], which becomes shift[0] after the shift.
              shift   <= shift >> 1;
              tx_o    <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            if (!empty) begin
              // Go straight into the next frame, with no idle gap.
              shift <= mem[rd_ptr];
              baud  <= BAUD_LOAD;
              tx_o  <= 1'b0;
              state <= START;
            end else begin
              tx_o  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud - BAUD_W'(1);
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
